// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state type and sizing helpers for serial_subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_borrow_chunk.sv
// borrow_chunk: combinational CHUNK-bit borrow-ripple subtractor, diff = x - y - bi
module borrow_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bi,
    output logic [CHUNK-1:0] diff,
    output logic             bo
);

    logic [CHUNK:0] br;

    always_comb begin
        br[0] = bi;
        for (int i = 0; i < CHUNK; i++) begin
            diff[i]  = x[i] ^ y[i] ^ br[i];
            br[i+1]  = (~x[i] & (y[i] | br[i])) | (y[i] & br[i]);
        end
        bo = br[CHUNK];
    end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: chunk-serial d = a - b - bin over WIDTH/CHUNK cycles with a registered borrow
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_width(NCHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("serial_subtractor: WIDTH must be a multiple of CHUNK");
    end

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_reg, b_reg, d_sh, d_fin;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] diff;
    logic             borrow_reg, bo, last;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign last      = cnt == CW'(NCHUNK - 1);

    borrow_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x    (a_reg[CHUNK*int'(cnt) +: CHUNK]),
        .y    (b_reg[CHUNK*int'(cnt) +: CHUNK]),
        .bi   (borrow_reg),
        .diff (diff),
        .bo   (bo)
    );

    always_comb begin
        d_fin = d_sh;
        d_fin[CHUNK*int'(cnt) +: CHUNK] = diff;
        state_nx = (state == IDLE && in_valid)  ? BUSY :
                   (state == BUSY && last)      ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            d_sh       <= '0;
            borrow_reg <= 1'b0;
            cnt        <= '0;
            d          <= '0;
            bout       <= 1'b0;
            zero       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_reg      <= a;
                b_reg      <= b;
                borrow_reg <= bin;
                cnt        <= '0;
            end
            if (state == BUSY) begin
                d_sh       <= d_fin;
                borrow_reg <= bo;
                cnt        <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    d    <= d_fin;
                    bout <= bo;
                    zero <= d_fin == '0;
                    ovf  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (d_fin[WIDTH-1] != a_reg[WIDTH-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench comparing serial_subtractor against an arithmetic model
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, bin = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, bout, zero, ovf;
    logic [W-1:0] a = '0, b = '0, d;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         zero;
        logic         ovf;
    } res_t;

    res_t exp_q[$];
    int   n_chk = 0, n_fail = 0;

    serial_subtractor #(.WIDTH(W), .CHUNK(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer subtraction, unsigned for borrow and signed range for overflow
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        res_t r;
        int   u, s;
        u      = int'(x) - int'(y) - int'(c);
        s      = int'($signed(x)) - int'($signed(y)) - int'(c);
        r.d    = u[W-1:0];
        r.bout = u < 0;
        r.zero = r.d == '0;
        r.ovf  = (s < -(2 ** (W - 1))) || (s >= 2 ** (W - 1));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got d=%0h with no expected entry", d);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("d", d, e.d);
                chk("bout", bout, e.bout);
                chk("zero", zero, e.zero);
                chk("ovf", ovf, e.ovf);
            end
        end
    end

    task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit push);
        int n = 0;
        a = x;
        b = y;
        bin = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        if (push) exp_q.push_back(model(x, y, c));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
    endtask

    task automatic finish_op(input int hold, input bit early);
        int   lat = 0;
        res_t snap;
        out_ready = early;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 50);
        chk("latency", lat, 4);
        if (out_valid) begin
            snap = {d, bout, zero, ovf};
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
                @(posedge clk);
                #1;
                chk("hold_d", d, snap.d);
                chk("hold_flags", {bout, zero, ovf}, {snap.bout, snap.zero, snap.ovf});
                chk("hold_in_ready", in_ready, 0);
                chk("hold_out_valid", out_valid, 1);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("idle_in_ready", in_ready, 1);
            chk("idle_out_valid", out_valid, 0);
        end
    endtask

    logic [W-1:0] da [9] = '{8'h35, 8'h12, 8'h80, 8'h00, 8'h05, 8'h00, 8'h7F, 8'hFF, 8'h80};
    logic [W-1:0] db [9] = '{8'h12, 8'h35, 8'h01, 8'h00, 8'h05, 8'hFF, 8'h80, 8'hFF, 8'h7F};
    logic         dc [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_d", d, 0);
        chk("rst_flags", {bout, zero, ovf}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            start(da[i], db[i], dc[i], 1);
            finish_op(0, 0);
        end
        start(8'hA7, 8'h3C, 1'b1, 1);
        finish_op(3, 0);
        start(8'h9C, 8'h21, 1'b0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_d", d, 0);
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start(8'hFF, 8'h0F, 1'b0, 1);
        finish_op(0, 0);
        repeat (40) begin
            int h;
            h = $urandom_range(0, 3);
            start(W'($urandom), W'($urandom), 1'($urandom), 1);
            finish_op(h, (h == 0) && 1'($urandom));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
